// File: rtl/keycode_pio_pkg.sv
// Shared register map and bit positions for the keycode PIO peripheral.
package keycode_pio_pkg;

    // Avalon word addresses
    localparam logic [2:0] ADDR_CH0  = 3'd0;
    localparam logic [2:0] ADDR_EVT  = 3'd4;
    localparam logic [2:0] ADDR_CTRL = 3'd5;
    localparam logic [2:0] ADDR_CHG  = 3'd6;

    // EVT status word bit positions
    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_CNT_LSB = 8;

    // CTRL write bit positions
    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_OVF_CLR = 2;

endpackage

// File: rtl/keycode_sync_fifo.sv
// Single-clock first-word-fall-through FIFO for keycode events.
module keycode_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign count  = count_q;
    // A full FIFO still accepts a push when the head leaves in the same cycle;
    // flush wins over any pop.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero while empty so stale storage never shows.
    assign rdata   = empty ? '0 : mem[rptr];

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/keycode_fifo_pio.sv
// Avalon-MM keycode peripheral: channel registers with change capture,
// event FIFO with valid/ready output, and a registered interrupt.
module keycode_fifo_pio
    import keycode_pio_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [NUM_CH*DATA_W-1:0] key_out,
    output logic [DATA_W-1:0]        evt_data,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     irq
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic                 wr;
    logic [DATA_W-1:0]    wr_key;
    logic [DATA_W-1:0]    key_q [NUM_CH];
    logic [NUM_CH-1:0]    change_q;
    logic                 irq_en_q;
    logic                 ovf_q;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CNT_W-1:0]     fifo_count;
    logic                 unused_wdata;

    assign wr           = chipselect && !write_n;
    assign wr_key       = writedata[DATA_W-1:0];
    assign fifo_push    = wr && (address == ADDR_EVT);
    assign fifo_pop     = evt_valid && evt_ready;
    assign fifo_flush   = wr && (address == ADDR_CTRL) && writedata[CTRL_FLUSH];
    assign evt_valid    = !fifo_empty;
    assign unused_wdata = ^writedata;

    keycode_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (wr_key),
        .rdata (evt_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Channel registers and change capture; a channel write that alters the value flags it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                key_q[n] <= '0;
            end
            change_q <= '0;
        end else begin
            if (wr && (address == ADDR_CHG)) begin
                change_q <= change_q & ~writedata[NUM_CH-1:0];
            end
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (wr && (address == ADDR_CH0 + 3'(n))) begin
                    key_q[n] <= wr_key;
                    if (wr_key != key_q[n]) begin
                        change_q[n] <= 1'b1;
                    end
                end
            end
        end
    end

    // Control bits, sticky overflow and the registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr && (address == ADDR_CTRL)) begin
                irq_en_q <= writedata[CTRL_IRQ_EN];
                if (writedata[CTRL_OVF_CLR]) begin
                    ovf_q <= 1'b0;
                end
            end else if (fifo_push && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end
            irq <= irq_en_q && (|change_q);
        end
    end

    // Flatten channel registers onto key_out, channel 0 in the LSBs.
    always_comb begin
        key_out = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            key_out[n*DATA_W +: DATA_W] = key_q[n];
        end
    end

    // Zero-wait-state register readback.
    always_comb begin
        readdata = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (address == ADDR_CH0 + 3'(n)) begin
                readdata[DATA_W-1:0] = key_q[n];
            end
        end
        if (address == ADDR_EVT) begin
            readdata[ST_EMPTY]                 = fifo_empty;
            readdata[ST_FULL]                  = fifo_full;
            readdata[ST_OVF]                   = ovf_q;
            readdata[ST_CNT_LSB +: CNT_W]      = fifo_count;
        end else if (address == ADDR_CTRL) begin
            readdata[CTRL_IRQ_EN]              = irq_en_q;
        end else if (address == ADDR_CHG) begin
            readdata[NUM_CH-1:0]               = change_q;
        end
    end

endmodule

// File: tb/tb_keycode_fifo_pio.sv
// Directed bench for keycode_fifo_pio with an event scoreboard.
module tb_keycode_fifo_pio;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] key_out;
    logic [7:0]  evt_data;
    logic        evt_valid;
    logic        evt_ready;
    logic        irq;

    int          total;
    int          bad;
    logic [7:0]  sb_q [$];
    logic        ovf_m;
    logic [31:0] rd;
    logic        done;

    keycode_fifo_pio #(
        .DATA_W (8),
        .NUM_CH (4),
        .DEPTH  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .key_out    (key_out),
        .evt_data   (evt_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0]    = (sb_q.size() == 0);
        s[1]    = (sb_q.size() == 8);
        s[2]    = ovf_m;
        s[15:8] = 8'(sb_q.size());
        return s;
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    // Push one event; ready is held only for this cycle.
    task automatic push_evt(input logic [7:0] d, input logic rdy);
        @(negedge clk);
        evt_ready = rdy;
        address = 3'd4; writedata = {24'h0, d}; chipselect = 1'b1; write_n = 1'b0;
        if (sb_q.size() < 8 || (rdy && sb_q.size() > 0)) sb_q.push_back(d);
        else ovf_m = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; evt_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        evt_ready = 1'b1;
        while (evt_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        evt_ready = 1'b0;
        chk("drain_timeout", 32'(n < 20), 32'd1);
        chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard consumer: a pop is decided at the upcoming edge.
    always begin
        @(negedge clk);
        #2;
        if (!reset && evt_valid && evt_ready && !done) begin
            if (sb_q.size() == 0) begin
                chk("pop_unexpected", 32'(evt_data), 32'hFFFF_FFFF);
            end else begin
                chk("pop_data", 32'(evt_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        total = 0; bad = 0; ovf_m = 1'b0; done = 1'b0;
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_data", 32'(evt_data), 32'd0);
        chk("rst_key_out", key_out, 32'd0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            chk($sformatf("rst_read_%0d", a), rd, (a == 4) ? 32'h1 : 32'h0);
        end

        // Channels, change capture, irq
        bus_write(3'd5, 32'h1);
        bus_read(3'd5, rd);
        chk("ctrl_irq_en", rd, 32'h1);
        bus_write(3'd2, 32'h1A);
        chk("key_ch2", key_out, 32'h001A_0000);
        bus_read(3'd6, rd);
        chk("chg_after_ch2", rd, 32'h4);
        bus_read(3'd2, rd);
        chk("read_ch2", rd, 32'h1A);
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq), 32'd1);
        bus_write(3'd6, 32'h4);
        bus_read(3'd6, rd);
        chk("chg_cleared", rd, 32'h0);
        chk("irq_hold_one", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_fall", 32'(irq), 32'd0);
        bus_write(3'd2, 32'h1A);
        bus_read(3'd6, rd);
        chk("chg_same_value", rd, 32'h0);
        bus_write(3'd0, 32'h105);
        chk("key_ch0", key_out, 32'h001A_0005);
        bus_read(3'd6, rd);
        chk("chg_ch0", rd, 32'h1);
        bus_write(3'd6, 32'h1);
        bus_write(3'd7, 32'hFF);
        bus_read(3'd7, rd);
        chk("addr7_zero", rd, 32'h0);
        chk("addr7_no_key", key_out, 32'h001A_0005);

        // Overflow and ordered drain
        push_evt(8'h01, 1'b0);
        chk("fwft_valid", 32'(evt_valid), 32'd1);
        chk("fwft_data", 32'(evt_data), 32'h01);
        for (int i = 2; i <= 9; i++) push_evt(8'(i), 1'b0);
        bus_read(3'd4, rd);
        chk("status_full_ovf", rd, exp_status());
        chk("status_full_lit", rd, 32'h0000_0806);
        chk("head_stable", 32'(evt_data), 32'h01);
        drain();
        bus_read(3'd4, rd);
        chk("status_drained", rd, exp_status());

        // Full with simultaneous pop
        for (int i = 0; i < 8; i++) push_evt(8'h10 + 8'(i), 1'b0);
        push_evt(8'h55, 1'b1);
        bus_read(3'd4, rd);
        chk("status_full_pop", rd, exp_status());
        chk("status_full_pop_lit", rd, 32'h0000_0806);
        drain();

        // Flush and overflow clear
        for (int i = 0; i < 3; i++) push_evt(8'h21 + 8'(i), 1'b0);
        bus_write(3'd5, 32'h2);
        sb_q.delete();
        chk("flush_valid", 32'(evt_valid), 32'd0);
        bus_read(3'd4, rd);
        chk("flush_status", rd, exp_status());
        bus_write(3'd5, 32'h4);
        ovf_m = 1'b0;
        bus_read(3'd4, rd);
        chk("ovf_cleared", rd, 32'h1);

        // Asynchronous reset mid-operation
        bus_write(3'd5, 32'h1);
        bus_write(3'd1, 32'h33);
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_evt(8'h40 + 8'(i), 1'b0);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        address = 3'd4;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb_q.delete();
        ovf_m = 1'b0;
        chk("async_key_out", key_out, 32'd0);
        chk("async_valid", 32'(evt_valid), 32'd0);
        chk("async_irq", 32'(irq), 32'd0);
        chk("async_status", readdata, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        bus_read(3'd6, rd);
        chk("post_rst_chg", rd, 32'h0);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keycode_fifo_pio.md
# keycode_fifo_pio

Parametrised Avalon-MM keycode peripheral for the SoC's USB keyboard path. The NIOS II driver writes up to NUM_CH simultaneously held keycodes into parallel output registers and pushes key press/release events into an on-chip FIFO. Fabric logic consumes the events over a valid/ready stream. Per-channel change capture drives an interrupt so software and hardware can track key-state changes without polling.

## Interface
- DATA_W, 8, keycode width in bits; valid range 1..8.
- NUM_CH, 4, number of parallel keycode channels; valid range 1..4.
- DEPTH, 8, event FIFO depth; power of two, minimum 2.

- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, zero wait states.
- key_out  out  NUM_CH*DATA_W  channel registers concatenated; channel 0 in the LSBs.
- evt_data  out  DATA_W  FIFO head data.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head this cycle.
- irq  out  1  registered interrupt request.

## Operation
- A write is `chipselect && !write_n`. All writes take effect at the next clk edge.
- Register map:
  - Addresses 0..NUM_CH-1 (CHn), R/W: keycode for channel n = writedata[DATA_W-1:0]. Reads are zero-extended. Channel addresses at or above NUM_CH read 0 and ignore writes.
  - Address 4 (EVT), W: push writedata[DATA_W-1:0] into the FIFO.
  - Address 4 (EVT), R: status word. bit0 = empty, bit1 = full, bit2 = overflow (sticky), bits[15:8] = count. The read does not pop.
  - Address 5 (CTRL), W:
    - bit0 irq_en is stored.
    - bit1 = flush; self-clearing and never stored.
    - bit2 = write 1 to clear overflow.
  - Address 5 (CTRL), R: {31'b0, irq_en}.
  - Address 6 (CHG), R: change[NUM_CH-1:0]. W: write 1 to clear per bit.
  - Address 7: reads 0; writes are ignored.
- Change capture: a CHn write whose data differs from the current key_out slice sets change[n]. Rewriting the same value does not set it.
- Pop occurs when evt_valid && evt_ready. Data appears in FIFO order.
- Push when not full: accepted.
- Push when full:
  - With a simultaneous pop, the push is accepted and count is unchanged.
  - Without a pop, the data is dropped and overflow is set.
- Flush sets count to 0 at the edge. A pop in the same cycle is ignored. Overflow is unaffected. A push cannot coincide with a flush because the bus has a single port.
- Read and write pointers wrap modulo DEPTH. Count has width $clog2(DEPTH+1).

## Timing
- Reset values:
  - key_out = 0, change = 0, irq_en = 0, irq = 0.
  - FIFO empty, overflow = 0, evt_valid = 0, evt_data = 0.
  - readdata is combinational: reset with address = 4 reads 0x00000001.
- CHn write at edge T: key_out updates at T, and change[n] is set at T.
- irq <= irq_en && |change. irq therefore rises at edge T+1 after a change and falls one edge after the last bit is cleared or irq_en drops.
- EVT push at edge T into an empty FIFO: evt_valid = 1 and evt_data valid immediately after T (first-word fall-through). No bypass exists within cycle T.
- evt_data is held stable while evt_valid && !evt_ready.
- Status reflects the post-edge state, with combinational readback in the same cycle as address.
- Reset asserted mid-operation clears all state immediately; in-flight events are discarded.

## Structure
- Package keycode_pio_pkg holds:
  - address constants ADDR_CH0, ADDR_EVT, ADDR_CTRL, ADDR_CHG;
  - status bit positions ST_EMPTY, ST_FULL, ST_OVF, ST_CNT_LSB;
  - CTRL bit positions CTRL_IRQ_EN, CTRL_FLUSH, CTRL_OVF_CLR.
- Sub-module keycode_sync_fifo (parameters W, DEPTH) provides the following. Register decode, channel bank, change capture and irq stay in the top module.
  - ports: push, pop, flush, wdata, rdata, empty, full, count;
  - internal behaviour: pointers and the push-when-full-with-pop rule.

## Test plan
- Reset, then read addresses 0..6 -> all 0 except address 4 = 0x00000001; irq = 0, evt_valid = 0.
- Set irq_en = 1 (write 0x1 to address 5). Write 0x1A to address 2 -> key_out[23:16] = 0x1A and CHG = 0x4; irq = 1 one cycle later. Rewrite 0x1A -> no new change bit. Write 0x4 to address 6 -> irq = 0 one cycle later.
- With evt_ready = 0, push 0x01..0x09 -> status full, count = 8, overflow = 1. Drain -> 0x01..0x08 in order, then empty.
- With the FIFO full, push 0x55 while evt_ready = 1 -> push accepted, count stays 8, overflow unchanged, 0x55 delivered last.
- Push 3 events, then write 0x2 to address 5 -> evt_valid = 0 and count = 0 at the next edge; write 0x4 -> overflow cleared.
- Assert reset with 4 events queued and CHn nonzero -> key_out = 0, FIFO empty and irq = 0 immediately, without waiting for a clock edge.
